// File: rtl/bus_dest_bank_pkg.sv
// Shared types and constants for the 8080 bus destination bank.
package bus_dest_pkg;

  typedef enum logic [0:0] {
    IDLE,
    PAIR_LO
  } state_e;

  localparam int unsigned NUM_DEST = 9;

  // Register indices; index k corresponds to select_k / data_k.
  localparam logic [3:0] IDX_B = 4'd0;
  localparam logic [3:0] IDX_C = 4'd1;
  localparam logic [3:0] IDX_D = 4'd2;
  localparam logic [3:0] IDX_E = 4'd3;
  localparam logic [3:0] IDX_H = 4'd4;
  localparam logic [3:0] IDX_L = 4'd5;
  localparam logic [3:0] IDX_6 = 4'd6;
  localparam logic [3:0] IDX_7 = 4'd7;
  localparam logic [3:0] IDX_8 = 4'd8;

  // Bit k set when register k may start a high/low pair (k = 0, 2, 4, 6).
  localparam logic [NUM_DEST-1:0] PAIR_BASE = 9'b0_0101_0101;

  function automatic logic is_pair_base(input logic [3:0] idx);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (PAIR_BASE[i] && (idx == 4'(i))) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bus_dest_bank_if.sv
// Write-side bus of the destination bank: data, handshake, strobes and status.
interface bus_dest_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] bus_in;
  logic             wr_valid;
  logic             wr_ready;
  logic             select_0;
  logic             select_1;
  logic             select_2;
  logic             select_3;
  logic             select_4;
  logic             select_5;
  logic             select_6;
  logic             select_7;
  logic             select_8;
  logic             pair_wr;
  logic             wr_done;
  logic             busy;

  modport master (
    output bus_in, wr_valid, pair_wr,
    output select_0, select_1, select_2, select_3, select_4,
    output select_5, select_6, select_7, select_8,
    input  wr_ready, wr_done, busy
  );

  modport slave (
    input  bus_in, wr_valid, pair_wr,
    input  select_0, select_1, select_2, select_3, select_4,
    input  select_5, select_6, select_7, select_8,
    output wr_ready, wr_done, busy
  );
endinterface

// File: rtl/bus_dest_bank_onehot_decode.sv
// One-hot select vector to binary index. Vector order {select_0..select_8},
// select_0 in the MSB. onehot_ok is low for all-zero or multi-hot vectors.
module onehot_decode
  import bus_dest_pkg::*;
(
  input  logic [NUM_DEST-1:0] sel,
  output logic [3:0]          idx,
  output logic                onehot_ok
);

  logic [3:0] cnt;

  // Priority-free encode plus population count for the legality flag.
  always_comb begin
    idx = 4'd0;
    cnt = 4'd0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (sel[NUM_DEST-1-k]) begin
        idx = 4'(k);
        cnt = cnt + 4'd1;
      end
    end
    onehot_ok = (cnt == 4'd1);
  end

endmodule

// File: rtl/bus_dest_bank.sv
// Destination register bank on the 8080 internal data bus. Single-byte and
// two-beat pair (high then low) loads over a valid/ready handshake.
// Optional macro BUS_DEST_ONEHOT_CHECK_EN: illegal requests set a sticky err.
module bus_dest_bank
  import bus_dest_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  bus_dest_bank_if.slave   wr,
  input  logic             err_clr,
  output logic             err,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic [WIDTH-1:0] data_4,
  output logic [WIDTH-1:0] data_5,
  output logic [WIDTH-1:0] data_6,
  output logic [WIDTH-1:0] data_7,
  output logic [WIDTH-1:0] data_8
);

  state_e               state_q, state_d;
  logic [3:0]           pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 we, illegal, accept, onehot_ok;
  logic [3:0]           widx, idx;
  logic [NUM_DEST-1:0]  sel;
  logic [WIDTH-1:0]     data_q [NUM_DEST];

  assign sel = {wr.select_0, wr.select_1, wr.select_2, wr.select_3, wr.select_4,
                wr.select_5, wr.select_6, wr.select_7, wr.select_8};

  onehot_decode u_decode (
    .sel       (sel),
    .idx       (idx),
    .onehot_ok (onehot_ok)
  );

  assign wr.wr_ready = ~reset;
  assign accept      = wr.wr_valid & wr.wr_ready;
  assign wr.wr_done  = done_q;
  assign wr.busy     = (state_q == PAIR_LO);

  // Next-state, write enable and illegal-request detection.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    we      = 1'b0;
    widx    = idx;
    illegal = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr.pair_wr) begin
            if (onehot_ok && is_pair_base(idx)) begin
              we      = 1'b1;
              pend_d  = idx + 4'd1;
              state_d = PAIR_LO;
            end else begin
              illegal = 1'b1;
            end
          end else if (onehot_ok) begin
            we     = 1'b1;
            done_d = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      PAIR_LO: begin
        // Low byte goes to the latched target; select/pair_wr are ignored.
        if (accept) begin
          we      = 1'b1;
          widx    = pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, pending low-byte target, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Register file: only the addressed entry updates on a write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DEST; i++) begin
      if (reset) begin
        data_q[i] <= RESET_VAL;
      end else if (we && (widx == 4'(i))) begin
        data_q[i] <= wr.bus_in;
      end
    end
  end

`ifdef BUS_DEST_ONEHOT_CHECK_EN
  logic err_q;

  // Sticky error; a new error on the clearing edge takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (err_q & ~err_clr) | illegal;
    end
  end

  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_clr | illegal;
  assign err        = 1'b0;
`endif

  assign data_0 = data_q[0];
  assign data_1 = data_q[1];
  assign data_2 = data_q[2];
  assign data_3 = data_q[3];
  assign data_4 = data_q[4];
  assign data_5 = data_q[5];
  assign data_6 = data_q[6];
  assign data_7 = data_q[7];
  assign data_8 = data_q[8];

endmodule

// File: tb/tb_bus_dest_bank.sv
// Self-checking bench for bus_dest_bank: table of single-cycle steps plus
// hand-written reset and pair sequences.
module tb_bus_dest_bank;

`ifdef BUS_DEST_ONEHOT_CHECK_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       err_clr;
  logic       err;
  logic [7:0] d [9];
  logic [7:0] exp_regs [9];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  bus_dest_bank_if #(.WIDTH(8)) bif ();

  bus_dest_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (bif.slave),
    .err_clr (err_clr),
    .err     (err),
    .data_0  (d[0]),
    .data_1  (d[1]),
    .data_2  (d[2]),
    .data_3  (d[3]),
    .data_4  (d[4]),
    .data_5  (d[5]),
    .data_6  (d[6]),
    .data_7  (d[7]),
    .data_8  (d[8])
  );

  typedef struct {
    logic       valid;
    logic       pair;
    logic [8:0] sel;     // {select_0..select_8}
    logic [7:0] bus;
    logic       clr;
    logic       exp_done;
    logic       exp_busy;
    logic       exp_err;
    logic       we;      // expected register update from this step
    int         widx;
    logic [7:0] wval;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] oh(input int k);
    logic [8:0] one;
    one = 9'd1;
    return one << (8 - k);
  endfunction

  function automatic vec_t mk(input logic valid, input logic pair, input logic [8:0] sel,
                              input logic [7:0] bus, input logic clr, input logic done,
                              input logic busy, input logic e, input logic we,
                              input int widx, input logic [7:0] wval);
    vec_t v;
    v.valid = valid; v.pair = pair; v.sel = sel; v.bus = bus; v.clr = clr;
    v.exp_done = done; v.exp_busy = busy; v.exp_err = e;
    v.we = we; v.widx = widx; v.wval = wval;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic pair, input logic [8:0] sel,
                       input logic [7:0] bus, input logic clr);
    bif.wr_valid = valid;
    bif.pair_wr  = pair;
    bif.bus_in   = bus;
    err_clr      = clr;
    bif.select_0 = sel[8]; bif.select_1 = sel[7]; bif.select_2 = sel[6];
    bif.select_3 = sel[5]; bif.select_4 = sel[4]; bif.select_5 = sel[3];
    bif.select_6 = sel[2]; bif.select_7 = sel[1]; bif.select_8 = sel[0];
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s data_%0d", tag, i), {24'd0, d[i]}, {24'd0, exp_regs[i]});
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("reset wr_ready", {31'd0, bif.wr_ready}, 32'd1);
    check("reset wr_done", {31'd0, bif.wr_done}, 32'd0);
    check("reset busy", {31'd0, bif.busy}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check_regs("reset");

    //               valid pair sel              bus    clr  done busy err    we  idx val
    vecs.push_back(mk(1, 0, oh(3),             8'hA5, 0,   1,   0,   0,     1,  3,  8'hA5));
    vecs.push_back(mk(0, 0, 9'd0,              8'hFF, 0,   0,   0,   0,     0,  0,  8'h00));
    // Pair load into 2/3, garbage selects on the low beat
    vecs.push_back(mk(1, 1, oh(2),             8'h12, 0,   0,   1,   0,     1,  2,  8'h12));
    vecs.push_back(mk(0, 0, 9'h1FF,            8'hEE, 0,   0,   1,   0,     0,  0,  8'h00));
    vecs.push_back(mk(1, 0, 9'h1FF,            8'h34, 0,   1,   0,   0,     1,  3,  8'h34));
    vecs.push_back(mk(0, 0, 9'd0,              8'h00, 0,   0,   0,   0,     0,  0,  8'h00));
    // Multi-hot select, then clear
    vecs.push_back(mk(1, 0, oh(1) | oh(5),     8'h77, 0,   0,   0,   ErrEn, 0,  0,  8'h00));
    vecs.push_back(mk(0, 0, 9'd0,              8'h00, 1,   0,   0,   0,     0,  0,  8'h00));
    // Illegal pair bases (8 and odd 3)
    vecs.push_back(mk(1, 1, oh(8),             8'h55, 0,   0,   0,   ErrEn, 0,  0,  8'h00));
    // Clear and new error (all-zero select) on the same edge: set wins
    vecs.push_back(mk(1, 0, 9'd0,              8'h66, 1,   0,   0,   ErrEn, 0,  0,  8'h00));
    vecs.push_back(mk(0, 0, 9'd0,              8'h00, 1,   0,   0,   0,     0,  0,  8'h00));
    vecs.push_back(mk(1, 1, oh(3),             8'h99, 0,   0,   0,   ErrEn, 0,  0,  8'h00));
    vecs.push_back(mk(0, 0, 9'd0,              8'h00, 1,   0,   0,   0,     0,  0,  8'h00));
    // Pair load into 4/5; low beat carries pair_wr and a select that must be ignored
    vecs.push_back(mk(1, 1, oh(4),             8'hAB, 0,   0,   1,   0,     1,  4,  8'hAB));
    vecs.push_back(mk(1, 1, oh(1),             8'hCD, 0,   1,   0,   0,     1,  5,  8'hCD));
    // Back-to-back single writes, valid held high
    for (int n = 0; n < 9; n++) begin
      vecs.push_back(mk(1, 0, oh(n), 8'h10 + 8'(n), 0, 1, 0, 0, 1, n, 8'h10 + 8'(n)));
    end
    vecs.push_back(mk(0, 0, 9'd0,              8'h00, 0,   0,   0,   0,     0,  0,  8'h00));

    foreach (vecs[r]) begin
      drive(vecs[r].valid, vecs[r].pair, vecs[r].sel, vecs[r].bus, vecs[r].clr);
      check($sformatf("row%0d wr_ready", r), {31'd0, bif.wr_ready}, 32'd1);
      tick();
      if (vecs[r].we) exp_regs[vecs[r].widx] = vecs[r].wval;
      check($sformatf("row%0d wr_done", r), {31'd0, bif.wr_done}, {31'd0, vecs[r].exp_done});
      check($sformatf("row%0d busy", r), {31'd0, bif.busy}, {31'd0, vecs[r].exp_busy});
      check($sformatf("row%0d err", r), {31'd0, err}, {31'd0, vecs[r].exp_err});
      check_regs($sformatf("row%0d", r));
    end

    // Reset in PAIR_LO abandons the pair
    drive(1'b1, 1'b1, oh(0), 8'h99, 1'b0);
    tick();
    check("pair_rst busy before", {31'd0, bif.busy}, 32'd1);
    drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    check("pair_rst busy", {31'd0, bif.busy}, 32'd0);
    check("pair_rst wr_done", {31'd0, bif.wr_done}, 32'd0);
    check_regs("pair_rst");
    // Next beat must be a plain single write (back in IDLE), not a low byte
    drive(1'b1, 1'b0, oh(6), 8'h3C, 1'b0);
    tick();
    drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0);
    exp_regs[6] = 8'h3C;
    check("post_rst wr_done", {31'd0, bif.wr_done}, 32'd1);
    check("post_rst busy", {31'd0, bif.busy}, 32'd0);
    check_regs("post_rst");
    tick();
    check("post_rst done pulse", {31'd0, bif.wr_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_dest_bank.md
Name: bus_dest_bank

Overview:
Destination side of the 8080 internal data bus. It captures the 8-bit bus value into one of nine 8-bit registers, selected by one-hot load strobes. The nine register outputs, data_0..data_8, feed the source-select bus multiplexer. It supports single-byte loads and two-beat register-pair loads (high byte, then low byte) over a valid/ready handshake.

Parameters:
WIDTH, 8, bit width of the bus and of each register.
RESET_VAL, 8'h00, value of every register after reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
bus_in  input  WIDTH  internal bus value to be written
wr_valid  input  1  write request; held until accepted
wr_ready  output  1  block can accept a beat this cycle
select_0..select_8  input  1 each  one-hot destination strobes; vector order {select_0..select_8}, select_0 is MSB
pair_wr  input  1  with wr_valid in IDLE: two-beat pair load starting at the selected register
err_clr  input  1  clears err
wr_done  output  1  one-cycle pulse when a single write or the second pair beat commits
busy  output  1  high while waiting for the second pair beat
err  output  1  sticky illegal-request flag
data_0..data_8  output  WIDTH each  register contents

Behaviour:
- Reset:
  - Applied only on a clk edge with reset=1 (synchronous, active-high).
  - All data_n = RESET_VAL; state = IDLE; wr_ready=1; wr_done=0; busy=0; err=0.
  - Reset asserted in PAIR_LO abandons the pair; no partial-write recovery.
- States: IDLE, PAIR_LO.
- wr_ready = 1 in both states when not in reset.
- A beat is accepted on a clk edge where wr_valid & wr_ready.
- IDLE, accepted beat, pair_wr=0, legal one-hot select k:
  - data_k <= bus_in at that edge; visible the next cycle.
  - wr_done pulses in the cycle after the edge.
- IDLE, accepted beat, pair_wr=1, select k with k in {0,2,4,6}:
  - data_k <= bus_in (high byte); latch k+1 as the pending target.
  - Go to PAIR_LO; busy=1; no wr_done.
- PAIR_LO, accepted beat:
  - data_(k+1) <= bus_in; select and pair_wr are ignored.
  - Return to IDLE; busy=0; wr_done pulses.
- Illegal request in IDLE (select all-zero, multi-hot, or pair_wr=1 with k odd or k=8):
  - Beat is consumed but no register changes and no wr_done.
  - err handling depends on the macro (see Optional Feature).
- err_clr=1 clears err on that edge. If a new error occurs on the same edge, set wins.
- Writes occur only on accepted beats; idle cycles leave all registers unchanged.
- Back-to-back accepted beats are permitted every cycle (full throughput, no bubbles).
- Latency: accept edge to data_n update = 0 cycles (registered at that edge); accept to wr_done = 1 cycle.

Optional Feature:
Macro BUS_DEST_ONEHOT_CHECK_EN.
- Defined: illegal requests set err (sticky until err_clr or reset).
- Undefined: illegal requests are silently dropped; err is tied to 0; err_clr is ignored.
- Write behaviour is otherwise identical in both builds.

Decomposition:
- Package bus_dest_pkg:
  - state enum {IDLE, PAIR_LO}
  - NUM_DEST=9
  - register index constants (IDX_B=0 .. IDX_8=8)
  - PAIR_BASE mask of legal pair-start indices
- Sub-module onehot_decode: 9-bit select vector -> 4-bit index plus onehot_ok flag. Purely combinational; reused by the source-side controller.

Test Plan:
- Reset: after reset, all data_n=8'h00, wr_ready=1, err=0. Assert reset in PAIR_LO: state returns to IDLE and busy=0.
- Single write: bus_in=8'hA5, select_3 only, wr_valid for one cycle -> data_3=8'hA5 next cycle, wr_done pulses once, other registers unchanged.
- Pair load: pair_wr=1, select_2, bus_in=8'h12, then bus_in=8'h34 with select lines set to garbage -> data_2=8'h12, data_3=8'h34, busy high only between the two beats, one wr_done.
- Illegal select: select_1 and select_5 both high with 8'h77 -> no register changes, no wr_done; err=1 with the macro, 0 without. Then err_clr -> err=0.
- Illegal pair: pair_wr=1, select_8 -> no write, stays IDLE, err=1 with the macro.
- Throughput: 9 consecutive single writes of 8'h10+n to register n, wr_valid held high -> every beat accepted on consecutive edges, final data_n=8'h10+n.
